// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl
// ---------------
// Double-buffer sequencing controller for a VGA frame-buffer pair. Owns the
// front/back buffer select and gates drawing-engine access to the back
// buffer. A buffer swap happens only on the first cycle of vertical blanking,
// so scanout never shows a torn frame. After a swap the new back buffer can
// optionally be cleared by streaming a fill colour to every pixel address.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   vblank_start  one-cycle pulse at the first cycle of vertical blanking
//   swap_req      drawer asks to present the back buffer (level, held to ack)
//   swap_ack      one-cycle pulse: swap performed
//   front_sel     buffer index read by scanout
//   back_sel      ~front_sel; buffer index written by drawer / clear
//   draw_en       drawer may write the back buffer
//   clear_en      clear the new back buffer after a swap (sampled in SWAP)
//   clear_color   fill value (latched in SWAP)
//   clr_we        clear write strobe
//   clr_addr      clear write address, row-major y*WIDTH+x
//   clr_data      clear write data (latched clear_color)
//   frame_count   swaps performed, wraps
//   repeat_count  vblanks that did not swap (frame re-shown), saturates
//
// Every output is a register loaded from the next-state logic, so each output
// describes the state the FSM has just entered.

module frame_swap_ctrl #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int PIXEL_SIZE = 8,
  parameter int ADDR_W     = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank_start,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  front_sel,
  output logic                  back_sel,
  output logic                  draw_en,
  input  logic                  clear_en,
  input  logic [PIXEL_SIZE-1:0] clear_color,
  output logic                  clr_we,
  output logic [ADDR_W-1:0]     clr_addr,
  output logic [PIXEL_SIZE-1:0] clr_data,
  output logic [15:0]           frame_count,
  output logic [15:0]           repeat_count
);

  localparam int unsigned       NUM_PIXELS = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_DRAW,
    ST_WAIT_VB,
    ST_SWAP,
    ST_CLEAR
  } state_t;

  state_t                state_q, state_d;
  logic                  front_sel_d;
  logic                  swap_ack_d;
  logic                  clr_we_d;
  logic                  draw_en_d;
  logic [ADDR_W-1:0]     clr_addr_d;
  logic [PIXEL_SIZE-1:0] clr_data_d;
  logic [15:0]           frame_count_d;
  logic [15:0]           repeat_count_d;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d        = state_q;
    front_sel_d    = front_sel;
    swap_ack_d     = 1'b0;
    clr_addr_d     = clr_addr;
    clr_data_d     = clr_data;
    frame_count_d  = frame_count;
    repeat_count_d = repeat_count;

    case (state_q)
      ST_DRAW: begin
        if (swap_req && vblank_start) state_d = ST_SWAP;
        else if (swap_req)            state_d = ST_WAIT_VB;
      end
      // The request is committed here; swap_req is not looked at again.
      ST_WAIT_VB: begin
        if (vblank_start) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        clr_data_d = clear_color;
        clr_addr_d = '0;
        state_d    = clear_en ? ST_CLEAR : ST_DRAW;
      end
      // clr_addr holds the address written in the current cycle.
      ST_CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          state_d    = ST_DRAW;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr + ADDR_W'(1);
        end
      end
      default: state_d = ST_DRAW;
    endcase

    // A vblank either causes the swap or counts as a re-shown frame.
    if (state_d == ST_SWAP) begin
      front_sel_d   = ~front_sel;
      swap_ack_d    = 1'b1;
      frame_count_d = frame_count + 16'd1;
    end else if (vblank_start && (repeat_count != 16'hffff)) begin
      repeat_count_d = repeat_count + 16'd1;
    end

    draw_en_d = (state_d == ST_DRAW);
    clr_we_d  = (state_d == ST_CLEAR);
  end

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_DRAW;
      front_sel    <= 1'b0;
      back_sel     <= 1'b1;
      draw_en      <= 1'b1;
      swap_ack     <= 1'b0;
      clr_we       <= 1'b0;
      clr_addr     <= '0;
      clr_data     <= '0;
      frame_count  <= '0;
      repeat_count <= '0;
    end else begin
      state_q      <= state_d;
      front_sel    <= front_sel_d;
      back_sel     <= ~front_sel_d;
      draw_en      <= draw_en_d;
      swap_ack     <= swap_ack_d;
      clr_we       <= clr_we_d;
      clr_addr     <= clr_addr_d;
      clr_data     <= clr_data_d;
      frame_count  <= frame_count_d;
      repeat_count <= repeat_count_d;
    end
  end

endmodule
